// File: rtl/scan_pkg.sv
// Shared definitions for the pan/tilt raster-scan sequencer: FSM states,
// serial frame markers and the servo rest position.
package scan_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_TRIG,
    S_MEAS,
    S_SEND,
    S_NEXT,
    S_END,
    S_FIN
  } state_t;

  localparam logic [7:0] F_SCAN_REC = 8'hAF;
  localparam logic [7:0] F_SCAN_END = 8'hAD;
  localparam int         POS_CENTER = 150;

endpackage

// File: rtl/scan_seq_timeout.sv
// Cycle timeout: counts enabled cycles from a clear and flags the cycle in
// which the programmed limit is reached.
module timeout #(
  parameter int CNT_LEN = 24
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [CNT_LEN-1:0] i_limit,
  output logic               o_expired
);

  logic [CNT_LEN-1:0] r_cnt;

  // Expires on the limit-th enabled cycle, so the caller spends exactly i_limit cycles waiting.
  assign o_expired = i_en && (r_cnt == (i_limit - CNT_LEN'(1)));

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CNT_LEN'(1);
    end
  end

endmodule

// File: rtl/scan_seq.sv
// Raster-scan sequencer: steps the servos over a window, settles, ranges each
// point and streams 5-byte records (AF,x,y,lenH,lenL) then an AD trailer.
module scan_seq
  import scan_pkg::*;
#(
  parameter int POS_LEN    = 8,
  parameter int CAP_LEN    = 16,
  parameter int SETTLE_LEN = 24,
  parameter int SETTLE_CYC = 5_000_000
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               start,
  input  logic               abort,
  input  logic [POS_LEN-1:0] x_min,
  input  logic [POS_LEN-1:0] x_max,
  input  logic [POS_LEN-1:0] y_min,
  input  logic [POS_LEN-1:0] y_max,
  input  logic [POS_LEN-1:0] step,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [POS_LEN-1:0] ser_x,
  output logic [POS_LEN-1:0] ser_y,
  output logic               hc_en,
  input  logic               hc_done,
  input  logic [CAP_LEN-1:0] hc_len,
  output logic [7:0]         tx_data,
  output logic               tx_send,
  input  logic               tx_busy
);

  localparam logic [SETTLE_LEN-1:0] SETTLE_LIM = SETTLE_LEN'(SETTLE_CYC);

  state_t             r_state;
  logic [2:0]         r_idx;
  logic               r_phase;
  logic               r_abort_pend;
  logic               r_err;
  logic               r_busy;
  logic               r_done;
  logic               r_hc_en;
  logic [POS_LEN-1:0] r_ser_x, r_ser_y;
  logic [7:0]         r_tx_data;
  logic               r_tx_send;
  logic [POS_LEN-1:0] r_xmin, r_xmax, r_ymin, r_ymax, r_step;
  logic [POS_LEN-1:0] r_x, r_y;
  logic [15:0]        r_len;

  state_t             w_state_nxt;
  logic [2:0]         w_idx_nxt;
  logic               w_phase_nxt, w_abort_nxt, w_err_nxt, w_busy_nxt;
  logic               w_done_nxt, w_hc_en_nxt, w_tx_send_nxt;
  logic [POS_LEN-1:0] w_ser_x_nxt, w_ser_y_nxt;
  logic [7:0]         w_tx_data_nxt;
  logic [POS_LEN-1:0] w_xmin_nxt, w_xmax_nxt, w_ymin_nxt, w_ymax_nxt, w_step_nxt;
  logic [POS_LEN-1:0] w_x_nxt, w_y_nxt;
  logic [15:0]        w_len_nxt;

  logic               w_abort;
  logic               w_settle_clr, w_settle_en, w_settle_done;
  logic [POS_LEN:0]   w_x_step, w_y_step;

  function automatic logic [7:0] rec_byte(input logic [2:0]         idx,
                                          input logic [POS_LEN-1:0] x,
                                          input logic [POS_LEN-1:0] y,
                                          input logic [15:0]        len);
    case (idx)
      3'd0:    rec_byte = F_SCAN_REC;
      3'd1:    rec_byte = 8'(x);
      3'd2:    rec_byte = 8'(y);
      3'd3:    rec_byte = len[15:8];
      default: rec_byte = len[7:0];
    endcase
  endfunction

  assign w_abort      = r_abort_pend | abort;
  assign w_settle_clr = (r_state == S_MOVE);
  assign w_settle_en  = (r_state == S_SETTLE) && !w_abort;
  // One extra bit so a step past the top of the servo range cannot wrap.
  assign w_x_step     = {1'b0, r_x} + {1'b0, r_step};
  assign w_y_step     = {1'b0, r_y} + {1'b0, r_step};

  timeout #(.CNT_LEN(SETTLE_LEN)) u_settle (
    .clk      (clk),
    .rst_i    (rst_i),
    .i_clr    (w_settle_clr),
    .i_en     (w_settle_en),
    .i_limit  (SETTLE_LIM),
    .o_expired(w_settle_done)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_phase_nxt   = r_phase;
    w_abort_nxt   = w_abort;
    w_err_nxt     = r_err;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_ser_x_nxt   = r_ser_x;
    w_ser_y_nxt   = r_ser_y;
    w_tx_data_nxt = r_tx_data;
    w_tx_send_nxt = r_tx_send;
    w_xmin_nxt    = r_xmin;
    w_xmax_nxt    = r_xmax;
    w_ymin_nxt    = r_ymin;
    w_ymax_nxt    = r_ymax;
    w_step_nxt    = r_step;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_len_nxt     = r_len;

    case (r_state)
      S_IDLE: begin
        w_abort_nxt = 1'b0;
        if (start) begin
          w_xmin_nxt = x_min;
          w_xmax_nxt = x_max;
          w_ymin_nxt = y_min;
          w_ymax_nxt = y_max;
          w_step_nxt = (step == '0) ? POS_LEN'(1) : step;
          w_busy_nxt = 1'b1;
          if ((x_min > x_max) || (y_min > y_max)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_END;
          end else begin
            w_err_nxt   = 1'b0;
            w_x_nxt     = x_min;
            w_y_nxt     = y_min;
            w_state_nxt = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        if (w_abort) begin
          w_state_nxt = S_END;
        end else begin
          w_ser_x_nxt = r_x;
          w_ser_y_nxt = r_y;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_abort)            w_state_nxt = S_END;
        else if (w_settle_done) w_state_nxt = S_TRIG;
      end
      S_TRIG: begin
        // Once the ranger has gone busy the measurement must run to completion.
        if (!hc_done)     w_state_nxt = S_MEAS;
        else if (w_abort) w_state_nxt = S_END;
      end
      S_MEAS: begin
        if (hc_done) begin
          w_len_nxt   = hc_len[15:0];
          w_state_nxt = w_abort ? S_END : S_SEND;
        end
      end
      S_SEND: begin
        if (!r_phase) begin
          if (tx_busy) begin
            w_tx_send_nxt = 1'b0;
            w_phase_nxt   = 1'b1;
          end
        end else if (!tx_busy) begin
          if (r_idx == 3'd4) begin
            w_state_nxt = w_abort ? S_END : S_NEXT;
          end else begin
            w_idx_nxt     = r_idx + 3'd1;
            w_tx_data_nxt = rec_byte(r_idx + 3'd1, r_x, r_y, r_len);
            w_tx_send_nxt = 1'b1;
            w_phase_nxt   = 1'b0;
          end
        end
      end
      S_NEXT: begin
        if (w_x_step > {1'b0, r_xmax}) begin
          w_x_nxt = r_xmin;
          if (w_y_step > {1'b0, r_ymax}) begin
            w_state_nxt = S_END;
          end else begin
            w_y_nxt     = w_y_step[POS_LEN-1:0];
            w_state_nxt = S_MOVE;
          end
        end else begin
          w_x_nxt     = w_x_step[POS_LEN-1:0];
          w_state_nxt = S_MOVE;
        end
      end
      S_END: begin
        w_abort_nxt = 1'b0;
        if (!r_phase) begin
          if (tx_busy) begin
            w_tx_send_nxt = 1'b0;
            w_phase_nxt   = 1'b1;
          end
        end else if (!tx_busy) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_abort_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Entry actions: the first byte of a frame is presented on the entering edge.
    if ((w_state_nxt == S_SEND) && (r_state != S_SEND)) begin
      w_idx_nxt     = 3'd0;
      w_phase_nxt   = 1'b0;
      w_tx_send_nxt = 1'b1;
      w_tx_data_nxt = F_SCAN_REC;
    end
    if ((w_state_nxt == S_END) && (r_state != S_END)) begin
      w_phase_nxt   = 1'b0;
      w_tx_send_nxt = 1'b1;
      w_tx_data_nxt = F_SCAN_END;
    end
    if (w_state_nxt == S_FIN) begin
      w_done_nxt = 1'b1;
      w_busy_nxt = 1'b0;
    end
    w_hc_en_nxt = (w_state_nxt == S_TRIG);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_phase      <= 1'b0;
      r_abort_pend <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hc_en      <= 1'b0;
      r_ser_x      <= POS_LEN'(POS_CENTER);
      r_ser_y      <= POS_LEN'(POS_CENTER);
      r_tx_data    <= '0;
      r_tx_send    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_phase      <= w_phase_nxt;
      r_abort_pend <= w_abort_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_hc_en      <= w_hc_en_nxt;
      r_ser_x      <= w_ser_x_nxt;
      r_ser_y      <= w_ser_y_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_send    <= w_tx_send_nxt;
    end
  end

  // Window, cursor and result are only read in states entered after they are loaded.
  always_ff @(posedge clk) begin
    r_xmin <= w_xmin_nxt;
    r_xmax <= w_xmax_nxt;
    r_ymin <= w_ymin_nxt;
    r_ymax <= w_ymax_nxt;
    r_step <= w_step_nxt;
    r_x    <= w_x_nxt;
    r_y    <= w_y_nxt;
    r_len  <= w_len_nxt;
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign ser_x   = r_ser_x;
  assign ser_y   = r_ser_y;
  assign hc_en   = r_hc_en;
  assign tx_data = r_tx_data;
  assign tx_send = r_tx_send;

endmodule

// File: tb/tb_scan_seq.sv
// Bench for scan_seq: ranger and transmitter models, a byte/point model built
// from the window rules, and a per-cycle compare process.
module tb_scan_seq;

  localparam int SC = 20;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  x_min = '0, x_max = '0, y_min = '0, y_max = '0, step = '0;
  logic        busy, done, err, hc_en, tx_send;
  logic [7:0]  ser_x, ser_y, tx_data;
  logic        hc_done = 1'b1;
  logic [15:0] hc_len;
  logic        tx_busy = 1'b0;

  always #5 clk = ~clk;

  scan_seq #(.POS_LEN(8), .CAP_LEN(16), .SETTLE_LEN(24), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_i(rst_i), .start(start), .abort(abort),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .step(step),
    .busy(busy), .done(done), .err(err), .ser_x(ser_x), .ser_y(ser_y),
    .hc_en(hc_en), .hc_done(hc_done), .hc_len(hc_len),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Ranger: goes busy two edges after enable, returns hc_val after 7 more cycles.
  logic [15:0] hc_val = 16'h1234;
  int          hc_cnt = 0;
  assign hc_len = hc_val;
  always @(posedge clk) begin
    if (hc_done && hc_en) begin
      hc_done <= 1'b0;
      hc_cnt  <= 6;
    end else if (!hc_done) begin
      if (hc_cnt == 0) hc_done <= 1'b1;
      else             hc_cnt  <= hc_cnt - 1;
    end
  end

  // Transmitter: accepts after tx_lat cycles of tx_send, then busy for 3 cycles.
  int         tx_lat = 1;
  int         tx_wait = 0;
  int         tx_bcnt = 0;
  logic [7:0] got_q[$];
  always @(posedge clk) begin
    if (tx_busy) begin
      if (tx_bcnt <= 1) tx_busy <= 1'b0;
      else              tx_bcnt <= tx_bcnt - 1;
      tx_wait <= 0;
    end else if (tx_send) begin
      if (tx_wait >= tx_lat) begin
        got_q.push_back(tx_data);
        tx_busy <= 1'b1;
        tx_bcnt <= 3;
        tx_wait <= 0;
      end else begin
        tx_wait <= tx_wait + 1;
      end
    end else begin
      tx_wait <= 0;
    end
  end

  // Expected byte stream and measurement points derived from the window rules.
  logic [7:0]  exp_q[$];
  logic [15:0] exp_pts[$];

  task automatic build(input int xmin, input int xmax, input int ymin, input int ymax,
                       input int stp, input int maxpts);
    int s;
    int np;
    exp_q.delete();
    exp_pts.delete();
    s  = (stp == 0) ? 1 : stp;
    np = 0;
    if (xmin <= xmax && ymin <= ymax) begin
      for (int y = ymin; y <= ymax; y += s) begin
        for (int x = xmin; x <= xmax; x += s) begin
          if (np < maxpts) begin
            exp_q.push_back(8'hAF);
            exp_q.push_back(8'(x));
            exp_q.push_back(8'(y));
            exp_q.push_back(hc_val[15:8]);
            exp_q.push_back(hc_val[7:0]);
            exp_pts.push_back({8'(x), 8'(y)});
            np++;
          end
        end
      end
    end
    exp_q.push_back(8'hAD);
  endtask

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_done = 0;
  int          n_hc = 0;
  int          last_move = 0;
  logic [15:0] last_pos = {8'd150, 8'd150};
  logic        prev_send = 1'b0, prev_busy = 1'b0, prev_hcen = 1'b0, prev_trig = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [7:0]  b;

  always @(negedge clk) begin
    if (!rst_i) begin
      while (got_q.size() > 0) begin
        b = got_q.pop_front();
        if (exp_q.size() == 0) fail_now($sformatf("tx_byte_extra got 0x%0h expected none", b));
        else                   chk("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
      end
      if ({ser_x, ser_y} != last_pos) begin
        last_pos  = {ser_x, ser_y};
        last_move = cyc;
      end
      if (hc_en && !prev_hcen) begin
        n_hc++;
        if (exp_pts.size() == 0) fail_now($sformatf("meas_unexpected at %0d,%0d", ser_x, ser_y));
        else                     chk("meas_pos", {16'd0, ser_x, ser_y}, {16'd0, exp_pts.pop_front()});
        chk("settle_time", {31'd0, (cyc - last_move) >= SC}, 32'd1);
      end
      if (hc_en && !hc_done) chk("hc_en_in_meas", {31'd0, prev_trig}, 32'd0);
      if (prev_send && !prev_busy) chk("tx_send_held", {31'd0, tx_send}, 32'd1);
      if (tx_send && prev_send && !prev_busy) chk("tx_data_stable", {24'd0, tx_data}, {24'd0, prev_data});
      if (prev_busy && tx_busy) chk("tx_send_drop", {31'd0, tx_send}, 32'd0);
      if (done) n_done++;
    end
    prev_send = tx_send;
    prev_busy = tx_busy;
    prev_data = tx_data;
    prev_hcen = hc_en;
    prev_trig = hc_en && !hc_done;
  end

  task automatic kick(input int xmin, input int xmax, input int ymin, input int ymax, input int stp);
    @(negedge clk);
    x_min  = 8'(xmin);
    x_max  = 8'(xmax);
    y_min  = 8'(ymin);
    y_max  = 8'(ymax);
    step   = 8'(stp);
    n_done = 0;
    n_hc   = 0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string name, input logic exp_err);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) fail_now({name, " done_timeout"});
    repeat (3) @(negedge clk);
    chk({name, " done_pulses"}, n_done, 1);
    chk({name, " busy_low"}, {31'd0, busy}, 32'd0);
    chk({name, " err"}, {31'd0, err}, {31'd0, exp_err});
    chk({name, " bytes_left"}, exp_q.size(), 0);
    chk({name, " points_left"}, exp_pts.size(), 0);
  endtask

  task automatic wait_cond_ser20();
    for (int i = 0; i < 2000; i++) begin
      if (ser_x == 8'd20) return;
      @(negedge clk);
    end
    fail_now("wait_second_point timeout");
  endtask

  task automatic wait_rec_start();
    for (int i = 0; i < 2000; i++) begin
      if (tx_send && tx_data == 8'hAF) return;
      @(negedge clk);
    end
    fail_now("wait_record timeout");
  endtask

  task automatic wait_hcen(input logic lvl);
    for (int i = 0; i < 2000; i++) begin
      if (hc_en == lvl) return;
      @(negedge clk);
    end
    fail_now("wait_hc_en timeout");
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, " ser_x"}, {24'd0, ser_x}, 32'd150);
    chk({name, " ser_y"}, {24'd0, ser_y}, 32'd150);
    chk({name, " busy"}, {31'd0, busy}, 32'd0);
    chk({name, " done"}, {31'd0, done}, 32'd0);
    chk({name, " err"}, {31'd0, err}, 32'd0);
    chk({name, " hc_en"}, {31'd0, hc_en}, 32'd0);
    chk({name, " tx_send"}, {31'd0, tx_send}, 32'd0);
    chk({name, " tx_data"}, {24'd0, tx_data}, 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Invalid window: only the trailer, servos untouched, no ranging.
    build(40, 20, 0, 0, 10, 99);
    chk("model_err_len", exp_q.size(), 1);
    kick(40, 20, 0, 0, 10);
    wait_done("err_win", 1'b1);
    chk("err_win ser_x", {24'd0, ser_x}, 32'd150);
    chk("err_win ser_y", {24'd0, ser_y}, 32'd150);
    chk("err_win hc_count", n_hc, 0);

    // Basic row scan x 10..30, y 50.
    hc_val = 16'h1234;
    build(10, 30, 50, 50, 10, 99);
    chk("model_t1_len", exp_q.size(), 16);
    chk("model_t1_b6", {24'd0, exp_q[6]}, 32'h14);
    chk("model_t1_b7", {24'd0, exp_q[7]}, 32'h32);
    kick(10, 30, 50, 50, 10);
    wait_done("row", 1'b0);
    chk("row hc_count", n_hc, 3);
    chk("row last_x", {24'd0, ser_x}, 32'd30);

    // Top-of-range step must end the row rather than wrap; slow transmitter.
    hc_val = 16'hBEEF;
    tx_lat = 5;
    build(250, 255, 0, 0, 10, 99);
    chk("model_t3_len", exp_q.size(), 6);
    chk("model_t3_x", {24'd0, exp_q[1]}, 32'd250);
    kick(250, 255, 0, 0, 10);
    wait_done("nowrap", 1'b0);
    chk("nowrap hc_count", n_hc, 1);
    chk("nowrap ser_x", {24'd0, ser_x}, 32'd250);

    // Abort while settling on the second point.
    hc_val = 16'h1234;
    tx_lat = 1;
    build(10, 30, 50, 50, 10, 1);
    kick(10, 30, 50, 50, 10);
    wait_cond_ser20();
    repeat (5) @(negedge clk);
    pulse_abort();
    wait_done("abort_settle", 1'b0);
    chk("abort_settle hc_count", n_hc, 1);

    // Abort during the first record: record completes, then trailer.
    build(10, 30, 60, 60, 10, 1);
    kick(10, 30, 60, 60, 10);
    wait_rec_start();
    repeat (3) @(negedge clk);
    pulse_abort();
    wait_done("abort_send", 1'b0);
    chk("abort_send hc_count", n_hc, 1);

    // Reset while the ranger is measuring.
    build(60, 80, 50, 50, 10, 99);
    kick(60, 80, 50, 50, 10);
    wait_hcen(1'b1);
    wait_hcen(1'b0);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("mid_meas_reset");
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 100 && !hc_done; i++) @(negedge clk);
    chk("ranger_idle", {31'd0, hc_done}, 32'd1);

    // Clean two-row scan after reset, slow transmitter.
    hc_val = 16'h00FF;
    tx_lat = 5;
    build(60, 80, 50, 60, 10, 99);
    chk("model_t7_len", exp_q.size(), 31);
    kick(60, 80, 50, 60, 10);
    wait_done("after_reset", 1'b0);
    chk("after_reset hc_count", n_hc, 6);

    // Zero step behaves as step 1.
    hc_val = 16'hA55A;
    tx_lat = 0;
    build(5, 7, 0, 0, 0, 99);
    chk("model_t8_len", exp_q.size(), 16);
    kick(5, 7, 0, 0, 0);
    wait_done("step0", 1'b0);
    chk("step0 hc_count", n_hc, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
